// File: rtl/isa_host_master.sv
// ISA bus initiator: runs one 8-bit memory or I/O cycle per accepted command,
// with programmable setup/strobe/hold timing and IOCHRDY wait states with timeout.
module isa_host_master #(
    parameter int SETUP_CYCLES      = 2,
    parameter int MEM_STROBE_CYCLES = 6,
    parameter int IO_STROBE_CYCLES  = 10,
    parameter int HOLD_CYCLES       = 2,
    parameter int WAIT_MAX          = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [19:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [19:0] bus_a,
    output logic [7:0]  bus_d,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_in,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_aen,
    input  logic        bus_rdy
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;
    typedef enum logic [1:0] {MEMR = 2'b00, MEMW = 2'b01, IOR = 2'b10, IOW = 2'b11} cmd_t;

    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] MEM_LOAD   = 8'(MEM_STROBE_CYCLES - 1);
    localparam logic [7:0] IO_LOAD    = 8'(IO_STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] WAIT_LIM   = 8'(WAIT_MAX);

    state_t      state, state_n;
    cmd_t        typ;
    logic [7:0]  cnt, cnt_n;
    logic [7:0]  ext, ext_n;
    logic        accept;
    logic        strobe_done;
    logic        timed_out;
    logic [7:0]  rdata_q;
    logic        timeout_q;

    // Next-state and counter logic; cnt counts down the current phase length.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        state_n     = state;
        cnt_n       = cnt;
        ext_n       = ext;
        accept      = 1'b0;
        strobe_done = 1'b0;
        timed_out   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_n = SETUP;
                    cnt_n   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_n = STROBE;
                    cnt_n   = typ[1] ? IO_LOAD : MEM_LOAD;
                    ext_n   = 8'd0;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            STROBE: begin
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else if (bus_rdy) begin
                    strobe_done = 1'b1;
                end else if (ext < WAIT_LIM) begin
                    ext_n = ext + 8'd1;
                end else begin
                    strobe_done = 1'b1;
                    timed_out   = 1'b1;
                end
                if (strobe_done) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) state_n = RESP;
                else             cnt_n   = cnt - 8'd1;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with its phase.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state       <= IDLE;
            typ         <= MEMR;
            cnt         <= 8'd0;
            ext         <= 8'd0;
            rdata_q     <= 8'd0;
            timeout_q   <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'd0;
            rsp_timeout <= 1'b0;
            bus_a       <= 20'd0;
            bus_d       <= 8'd0;
            bus_d_oe    <= 1'b0;
            bus_memr_l  <= 1'b1;
            bus_memw_l  <= 1'b1;
            bus_ior_l   <= 1'b1;
            bus_iow_l   <= 1'b1;
            bus_aen     <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ext        <= ext_n;
            cmd_ready  <= (state_n == IDLE);
            rsp_valid  <= (state_n == RESP);
            bus_aen    <= 1'b0;
            bus_memr_l <= !(state_n == STROBE && typ == MEMR);
            bus_memw_l <= !(state_n == STROBE && typ == MEMW);
            bus_ior_l  <= !(state_n == STROBE && typ == IOR);
            bus_iow_l  <= !(state_n == STROBE && typ == IOW);

            if (accept) begin
                typ      <= cmd_t'(cmd_type);
                bus_a    <= cmd_addr;
                bus_d    <= cmd_wdata;
                bus_d_oe <= cmd_type[0];
            end

            // Read data is taken on the last strobe-low cycle, just before the strobe rises.
            if (strobe_done) begin
                timeout_q <= timed_out;
                if (timed_out)   rdata_q <= 8'hFF;
                else if (!typ[0]) rdata_q <= bus_in;
                else             rdata_q <= 8'd0;
            end

            if (state_n == RESP) begin
                bus_d_oe    <= 1'b0;
                rsp_rdata   <= rdata_q;
                rsp_timeout <= timeout_q;
            end else begin
                rsp_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_isa_host_master.sv
// Self-checking bench for isa_host_master: vector table plus scoreboard queue,
// with a bus-target model that drives IOCHRDY and read data.
module tb_isa_host_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'b00;
    logic [19:0] cmd_addr = 20'd0;
    logic [7:0]  cmd_wdata = 8'd0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic [19:0] bus_a;
    logic [7:0]  bus_d;
    logic        bus_d_oe;
    logic [7:0]  bus_in = 8'd0;
    logic        bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l;
    logic        bus_aen;
    logic        bus_rdy = 1'b1;

    isa_host_master #(.WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .bus_a(bus_a), .bus_d(bus_d), .bus_d_oe(bus_d_oe), .bus_in(bus_in),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
        .bus_aen(bus_aen), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  drive;     // target read data, presented only on the expected last strobe cycle
        int          rdy_low;   // IOCHRDY-low cycles starting at the last minimum strobe cycle
        int          exp_len;
        int          exp_lat;
        logic [7:0]  exp_rdata;
        logic        exp_to;
        int          k;
    } vec_t;

    vec_t vecs[9];
    vec_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc_cnt = 0;
    logic rst_at_edge = 1'b1;
    int   low_cnt = 0, oe_cnt = 0, kind_bad = 0, aen_bad = 0, rsp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    function automatic vec_t mk(logic [1:0] typ, logic [19:0] addr, logic [7:0] wdata,
                                logic [7:0] drive, int rdy_low, int exp_len, int exp_lat,
                                logic [7:0] exp_rdata, logic exp_to);
        vec_t v;
        v.typ = typ; v.addr = addr; v.wdata = wdata; v.drive = drive; v.rdy_low = rdy_low;
        v.exp_len = exp_len; v.exp_lat = exp_lat; v.exp_rdata = exp_rdata; v.exp_to = exp_to;
        v.k = 0;
        return v;
    endfunction

    always @(posedge clk) begin
        cyc_cnt     <= cyc_cnt + 1;
        rst_at_edge <= reset;
    end

    // Monitor, bus-target model and scoreboard comparison, all sampled on the falling edge.
    always @(negedge clk) begin
        vec_t       cur;
        logic [3:0] sv;
        int         mn;
        sv = {bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l};
        if (rst_at_edge) begin
            low_cnt = 0; oe_cnt = 0; kind_bad = 0; aen_bad = 0;
            bus_rdy = 1'b1;
        end else begin
            if (bus_aen) aen_bad++;
            if (exp_q.size() > 0) begin
                cur = exp_q[0];
                mn  = cur.typ[1] ? 10 : 6;
                if (sv != 4'hF) begin
                    low_cnt++;
                    if (sv != (4'hF ^ (4'b1000 >> cur.typ))) kind_bad++;
                    bus_rdy = !(low_cnt >= mn && low_cnt < mn + cur.rdy_low);
                    bus_in  = (low_cnt == cur.exp_len) ? cur.drive : ~cur.drive;
                end else begin
                    bus_rdy = 1'b1;
                    bus_in  = ~cur.drive;
                end
                if (bus_d_oe && bus_d == cur.wdata) oe_cnt++;
            end else begin
                bus_rdy = 1'b1;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("rsp_latency", cyc_cnt + 1 - cur.k, cur.exp_lat);
                    check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, cur.exp_rdata});
                    check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, cur.exp_to});
                    check("strobe_len", low_cnt, cur.exp_len);
                    check("strobe_kind_errs", kind_bad, 0);
                    check("oe_cycles", oe_cnt, cur.typ[0] ? cur.exp_len + 4 : 0);
                    check("bus_a_held", {12'd0, bus_a}, {12'd0, cur.addr});
                    check("aen_high_cycles", aen_bad, 0);
                    check("ready_in_resp", {31'd0, cmd_ready}, 32'd0);
                end
                low_cnt = 0; oe_cnt = 0; kind_bad = 0; aen_bad = 0;
            end
        end
    end

    task automatic issue(input vec_t v, input bit push);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("ready_wait", 32'd0, 32'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_type  = v.typ;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        v.k = cyc_cnt + 1;
        if (push) exp_q.push_back(v);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        vec_t a, b;
        int   n, rsp_before;

        //              typ    addr       wd     drive  rdyl len lat rdata  to
        vecs[0] = mk(2'b01, 20'hB0000, 8'h41, 8'h00,   0,  6, 11, 8'h00, 1'b0);
        vecs[1] = mk(2'b00, 20'hB0001, 8'h00, 8'h07,   0,  6, 11, 8'h07, 1'b0);
        vecs[2] = mk(2'b10, 20'h003BA, 8'h00, 8'hF1,   0, 10, 15, 8'hF1, 1'b0);
        vecs[3] = mk(2'b00, 20'hB0002, 8'h00, 8'h5A,   3,  9, 14, 8'h5A, 1'b0);
        vecs[4] = mk(2'b00, 20'hB0003, 8'h00, 8'h33, 200, 10, 15, 8'hFF, 1'b1);
        vecs[5] = mk(2'b11, 20'h003B8, 8'h29, 8'h00,   0, 10, 15, 8'h00, 1'b0);
        vecs[6] = mk(2'b01, 20'hB0FFF, 8'hC3, 8'h00,   0,  6, 11, 8'h00, 1'b0);
        vecs[7] = mk(2'b10, 20'h003BA, 8'h00, 8'h80,   4, 14, 19, 8'h80, 1'b0);
        vecs[8] = mk(2'b11, 20'h003B9, 8'h6E, 8'h00,  50, 14, 19, 8'hFF, 1'b1);

        repeat (3) @(negedge clk);
        check("rst_strobes", {28'd0, bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l}, 32'hF);
        check("rst_aen", {31'd0, bus_aen}, 32'd1);
        check("rst_bus_a", {12'd0, bus_a}, 32'd0);
        check("rst_bus_d", {24'd0, bus_d}, 32'd0);
        check("rst_oe", {31'd0, bus_d_oe}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_rsp", {23'd0, rsp_valid, rsp_rdata}, 32'd0);
        check("rst_timeout", {31'd0, rsp_timeout}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_rst_aen", {31'd0, bus_aen}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i], 1'b1);
            drain();
        end

        // cmd_valid held through a busy cycle: the second command waits for the next IDLE.
        a = mk(2'b00, 20'hB0010, 8'h00, 8'h3C, 0, 6, 11, 8'h3C, 1'b0);
        b = mk(2'b01, 20'hB0011, 8'h96, 8'h00, 0, 6, 11, 8'h00, 1'b0);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1;
        cmd_type = a.typ; cmd_addr = a.addr; cmd_wdata = a.wdata;
        a.k = cyc_cnt + 1;
        b.k = a.k + 12;
        exp_q.push_back(a);
        exp_q.push_back(b);
        @(negedge clk);
        cmd_type = b.typ; cmd_addr = b.addr; cmd_wdata = b.wdata;
        n = 0;
        while (cyc_cnt < b.k && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        drain();

        // Reset during STROBE of a write: outputs return to reset values, no response.
        issue(mk(2'b01, 20'hB00AA, 8'h55, 8'h00, 0, 6, 11, 8'h00, 1'b0), 1'b0);
        n = 0;
        while (bus_memw_l && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_strobe_seen", {31'd0, bus_memw_l}, 32'd0);
        rsp_before = rsp_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("abort_strobes", {28'd0, bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l}, 32'hF);
        check("abort_oe", {31'd0, bus_d_oe}, 32'd0);
        check("abort_aen", {31'd0, bus_aen}, 32'd1);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_no_rsp", rsp_cnt, rsp_before);

        issue(vecs[1], 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/isa_host_master.md
# isa_host_master

Synthesizable ISA bus initiator that runs single 8-bit memory and I/O cycles against the MDA/Hercules card's ISA target interface. It accepts one command at a time over a valid/ready handshake and produces correctly sequenced address, data, strobe and AEN signals with programmable setup, strobe and hold lengths. It honours IOCHRDY wait states with a timeout and returns read data or a timeout flag on a single-cycle response strobe. It is used in board bring-up harnesses and in the card's system-level bench as the host side of the bus.

## Interface
Parameters:
- SETUP_CYCLES, 2: cycles the address is stable before the strobe falls (1..255).
- MEM_STROBE_CYCLES, 6: minimum strobe-low cycles for MEMR/MEMW (1..255).
- IO_STROBE_CYCLES, 10: minimum strobe-low cycles for IOR/IOW (1..255).
- HOLD_CYCLES, 2: cycles the address and write data are held after the strobe rises (1..255).
- WAIT_MAX, 255: maximum IOCHRDY extension cycles before timeout (0..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_type  in  2  00 MEMR, 01 MEMW, 10 IOR, 11 IOW.
- cmd_addr  in  20  bus address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data; valid with rsp_valid.
- rsp_timeout  out  1  wait-state timeout; valid with rsp_valid.
- bus_a  out  20  ISA address.
- bus_d  out  8  host write data.
- bus_d_oe  out  1  host drives bus_d.
- bus_in  in  8  target read data.
- bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l  out  1 each  active-low strobes.
- bus_aen  out  1  address enable; 0 means CPU cycle.
- bus_rdy  in  1  IOCHRDY; 0 requests a wait state.

## Operation
- Every output is registered. Reset values: strobes 1, bus_aen 1, bus_a 0, bus_d 0, bus_d_oe 0, cmd_ready 0, rsp_valid 0, rsp_rdata 0, rsp_timeout 0, FSM IDLE.
- bus_aen is 0 whenever reset is low.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch type, addr and wdata, then go to SETUP. bus_a and bus_d update on that edge.
  - SETUP: run for SETUP_CYCLES. All strobes are high. bus_d_oe=1 for write commands.
  - STROBE: the selected strobe is low. Minimum length is MEM_STROBE_CYCLES or IO_STROBE_CYCLES by type.
  - HOLD: run for HOLD_CYCLES. Strobes are high. bus_a, bus_d and bus_d_oe are unchanged.
  - RESP: rsp_valid=1 for one cycle, then return to IDLE. bus_d_oe clears on entry to RESP.
- Wait states: after the minimum strobe count, each cycle with bus_rdy=0 extends STROBE by one cycle, to a maximum of WAIT_MAX extension cycles. bus_rdy is ignored before the minimum count expires.
- Timeout: if bus_rdy is still 0 after WAIT_MAX extensions, STROBE ends anyway. The response then carries rsp_timeout=1 and rsp_rdata=8'hFF.
- Read data: bus_in is sampled on the final STROBE cycle, the cycle before the strobe rises.
- Writes: rsp_rdata=0.
- Commands presented while cmd_ready=0 are ignored and not queued.
- There is no response backpressure. rsp_valid is never held.
- bus_a holds the last address in IDLE.
- Reset mid-operation: the FSM and all outputs return to reset values on the next edge. No rsp_valid is generated for the aborted command.
- Counters are 8 bits. The extension counter saturates and does not wrap.

## Timing
- Accept edge k. SETUP occupies cycles k+1..k+SETUP_CYCLES.
- STROBE starts at cycle k+1+SETUP_CYCLES and lasts N = min strobe + extensions.
- HOLD follows for HOLD_CYCLES.
- rsp_valid is high at cycle k+1+SETUP+N+HOLD. cmd_ready returns at the next cycle.
- Default memory cycle: rsp_valid at k+11, strobe low for cycles k+3..k+8.
- Default I/O cycle: rsp_valid at k+15.
- Minimum command-to-command spacing is SETUP+N+HOLD+2 cycles.

## Test plan
- MEMW, addr B0000h, data 41h, defaults:
  - bus_memw_l is low for exactly cycles k+3..k+8.
  - bus_d=41h with bus_d_oe=1 from k+1 through k+10.
  - rsp_valid at k+11 with rsp_timeout=0.
- MEMR, addr B0001h, bus_in=07h:
  - bus_memr_l is low for 6 cycles.
  - rsp_rdata=07h at k+11.
  - bus_d_oe stays 0 throughout.
- IOR, addr 3BAh, bus_in=F1h:
  - bus_ior_l is low for 10 cycles.
  - rsp_rdata=F1h at k+15.
  - bus_aen=0 throughout.
- MEMR with bus_rdy=0 for 3 cycles past the minimum strobe:
  - strobe is low for 9 cycles.
  - rsp_valid at k+14.
  - data is sampled on the last low cycle.
- Timeout, bus_rdy held 0 with WAIT_MAX=4:
  - strobe is low for 10 cycles.
  - rsp_timeout=1 and rsp_rdata=FFh.
  - the next command is accepted normally.
- Reset asserted during STROBE:
  - all strobes are 1, bus_d_oe=0 and bus_aen=1 next cycle.
  - no rsp_valid.
- cmd_valid held high during a busy cycle:
  - that command is not accepted.
  - the command is accepted on the first IDLE cycle after RESP.
